// File: rtl/bus_leader_arbiter_if.sv
// Interface bundling the requester-side and system_bus leader-side signals
// of bus_leader_arbiter.
// Optional feature macro: ARB_TIMEOUT_EN adds the per-requester rsp_error vector.
// Handshake: a requester asserts req_read/req_write with its command and holds
// it stable until the cycle where its req_ready bit is high; that cycle is the
// acceptance. rsp_valid[i] marks the single cycle in which rsp_data belongs to
// requester i. There is no backpressure on responses.
interface bus_leader_arbiter_if #(
   parameter int Leaders = 2
);
   // requester side
   logic [Leaders*32-1:0] req_addr;
   logic [Leaders-1:0]    req_read;
   logic [Leaders-1:0]    req_write;
   logic [Leaders*4-1:0]  req_byte_enable;
   logic [Leaders*32-1:0] req_write_data;
   logic [Leaders-1:0]    req_ready;
   logic [Leaders-1:0]    rsp_valid;
   logic [31:0]           rsp_data;
`ifdef ARB_TIMEOUT_EN
   logic [Leaders-1:0]    rsp_error;
`endif
   // system_bus leader side
   logic [31:0]           bus_addr;
   logic                  bus_read_req;
   logic                  bus_write_req;
   logic [3:0]            bus_byte_enable;
   logic [31:0]           bus_write_data;
   logic [31:0]           bus_read_data;
   logic                  bus_read_data_valid;
   // status / debug
   logic                  busy;
   logic                  state_dbg;

   // requesters and the follower (drive commands and read data)
   modport master (
      output req_addr, req_read, req_write, req_byte_enable, req_write_data,
      input  req_ready, rsp_valid, rsp_data,
`ifdef ARB_TIMEOUT_EN
      input  rsp_error,
`endif
      input  bus_addr, bus_read_req, bus_write_req, bus_byte_enable, bus_write_data,
      output bus_read_data, bus_read_data_valid,
      input  busy, state_dbg
   );

   // the arbiter itself
   modport slave (
      input  req_addr, req_read, req_write, req_byte_enable, req_write_data,
      output req_ready, rsp_valid, rsp_data,
`ifdef ARB_TIMEOUT_EN
      output rsp_error,
`endif
      output bus_addr, bus_read_req, bus_write_req, bus_byte_enable, bus_write_data,
      input  bus_read_data, bus_read_data_valid,
      output busy, state_dbg
   );
endinterface

// File: rtl/bus_leader_arbiter.sv
// Round-robin arbiter sharing one system_bus leader port between Leaders
// requesters. Grants are zero-latency; writes are posted, reads block the
// arbiter until their data returns and are routed back to the issuer.
// Optional feature macro: ARB_TIMEOUT_EN (read watchdog with rsp_error).
module bus_leader_arbiter #(
   parameter int Leaders = 2,
   parameter int Timeout = 16
) (
   input logic               clk,
   input logic               reset,
   bus_leader_arbiter_if.slave bus
);
   localparam int IW = $clog2(Leaders);
   localparam logic [IW-1:0] LAST_IDX = IW'(Leaders - 1);

   // elaboration-time range guard
   if (Leaders < 2 || Leaders > 8) begin : g_bad_leaders
      $error("bus_leader_arbiter: Leaders must be in 2..8");
   end
   if (Timeout < 2) begin : g_bad_timeout
      $error("bus_leader_arbiter: Timeout must be at least 2");
   end

   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_READ = 1'b1
   } state_t;

   state_t            state;
   logic [IW-1:0]     last;
   logic [IW-1:0]     owner;
   logic              busy_q;

   logic [Leaders-1:0] requesting;
   logic               found;
   logic [IW-1:0]      sel;
   logic [IW-1:0]      cand;
   logic               sel_read;
   logic               timeout_hit;
   logic               read_done;

   assign requesting = bus.req_read | bus.req_write;

   // round-robin search starting one past the last granted index, wrapping
   // explicitly at Leaders-1 so non-power-of-two counts work
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = last;
      for (int k = 0; k < Leaders; k++) begin
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
         if (!found && requesting[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   // a read wins over a write when both are (illegally) asserted together
   assign sel_read = bus.req_read[sel];

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(Timeout) + 1;
   logic [CW-1:0] wait_cnt;

   assign timeout_hit = (state == WAIT_READ) && (wait_cnt == CW'(Timeout - 1));

   // watchdog: cleared on entry to WAIT_READ, counts every cycle spent there
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // a read ends on returned data or, with the watchdog, on expiry
   assign read_done = bus.bus_read_data_valid || timeout_hit;

   // arbitration state, priority pointer and read owner
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         last   <= LAST_IDX;
         owner  <= '0;
         busy_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  last <= sel;
                  if (sel_read) begin
                     owner  <= sel;
                     state  <= WAIT_READ;
                     busy_q <= 1'b1;
                  end
               end
            end
            WAIT_READ: begin
               if (read_done) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy      = busy_q;
   assign bus.state_dbg = (state == WAIT_READ);

   // combinational grant, bus command mux and response routing; everything
   // is held quiet while reset is asserted
   always_comb begin
      bus.req_ready       = '0;
      bus.rsp_valid       = '0;
      bus.rsp_data        = bus.bus_read_data;
      bus.bus_addr        = '0;
      bus.bus_read_req    = 1'b0;
      bus.bus_write_req   = 1'b0;
      bus.bus_byte_enable = '0;
      bus.bus_write_data  = '0;
`ifdef ARB_TIMEOUT_EN
      bus.rsp_error       = '0;
`endif
      if (!reset) begin
         if (state == IDLE && found) begin
            bus.req_ready[sel] = 1'b1;
            for (int i = 0; i < Leaders; i++) begin
               if (sel == IW'(i)) begin
                  bus.bus_addr        = bus.req_addr[i*32 +: 32];
                  bus.bus_byte_enable = bus.req_byte_enable[i*4 +: 4];
                  bus.bus_write_data  = bus.req_write_data[i*32 +: 32];
               end
            end
            if (sel_read) begin
               bus.bus_read_req = 1'b1;
            end else begin
               bus.bus_write_req = 1'b1;
            end
         end else if (state == WAIT_READ && read_done) begin
            bus.rsp_valid[owner] = 1'b1;
`ifdef ARB_TIMEOUT_EN
            if (!bus.bus_read_data_valid) begin
               bus.rsp_error[owner] = 1'b1;
               bus.rsp_data         = 32'hDEAD_BEEF;
            end
`endif
         end
      end
   end
endmodule

// File: tb/tb_bus_leader_arbiter.sv
// Self-checking bench for bus_leader_arbiter: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_bus_leader_arbiter;
  localparam int L = 2;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_leader_arbiter_if #(.Leaders(L)) bif ();
  bus_leader_arbiter #(.Leaders(L), .Timeout(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  int checks = 0;
  int failures = 0;

  // reference model state
  bit m_busy;
  int m_last;
  int m_owner;
  int m_cnt;
  logic [31:0] exp_q[$];

  // per-cycle model decisions, consumed at the clock edge
  bit g_any, g_read, g_done;
  int g_sel;
  logic [31:0] g_addr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h2000_0000) return 32'h0000_000A;
    return (a ^ 32'h5A5A_1234) + 32'd7;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic set_cmd(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    bif.req_read[i] = rd;
    bif.req_write[i] = wr;
    bif.req_addr[i*32 +: 32] = a;
    bif.req_byte_enable[i*4 +: 4] = be;
    bif.req_write_data[i*32 +: 32] = wd;
  endtask

  task automatic clear_all();
    bif.req_read = '0;
    bif.req_write = '0;
    bif.req_addr = '0;
    bif.req_byte_enable = '0;
    bif.req_write_data = '0;
  endtask

  task automatic set_rsp(input bit v, input logic [31:0] d);
    bif.bus_read_data_valid = v;
    bif.bus_read_data = d;
  endtask

  // sample outputs mid-cycle and compare against the model's expectation
  task automatic sample();
    logic [L-1:0] e_ready, e_rv, e_err, rq;
    logic e_rr, e_wr, e_busy;
    logic [31:0] e_addr, e_wd, e_data;
    logic [3:0] e_be;
    bit vld, to_fire;
    int idx;
    #3;
    g_any = 0; g_read = 0; g_done = 0; g_sel = 0; g_addr = '0;
    e_ready = '0; e_rv = '0; e_err = '0; e_rr = 0; e_wr = 0; e_busy = 0;
    e_addr = '0; e_wd = '0; e_be = '0; e_data = bif.bus_read_data;
    vld = bif.bus_read_data_valid;
    to_fire = 0;
    if (reset) return;
    rq = bif.req_read | bif.req_write;
    if (!m_busy) begin
      for (int k = 1; k <= L; k++) begin
        idx = (m_last + k) % L;
        if (!g_any && rq[idx]) begin
          g_any = 1;
          g_sel = idx;
        end
      end
      if (g_any) begin
        e_ready = L'(1) << g_sel;
        e_addr = bif.req_addr[g_sel*32 +: 32];
        e_be = bif.req_byte_enable[g_sel*4 +: 4];
        e_wd = bif.req_write_data[g_sel*32 +: 32];
        g_addr = e_addr;
        if (bif.req_read[g_sel]) begin
          e_rr = 1;
          g_read = 1;
        end else begin
          e_wr = 1;
        end
      end
    end else begin
      e_busy = 1;
`ifdef ARB_TIMEOUT_EN
      to_fire = !vld && (m_cnt == TO - 1);
`endif
      g_done = vld || to_fire;
      if (g_done) begin
        e_rv = L'(1) << m_owner;
        if (to_fire) begin
          e_err = L'(1) << m_owner;
          e_data = 32'hDEAD_BEEF;
        end else if (exp_q.size() > 0) begin
          e_data = exp_q[0];
        end
      end
    end
    check("req_ready", 32'(bif.req_ready), 32'(e_ready));
    check("bus_read_req", 32'(bif.bus_read_req), 32'(e_rr));
    check("bus_write_req", 32'(bif.bus_write_req), 32'(e_wr));
    check("busy", 32'(bif.busy), 32'(e_busy));
    check("rsp_valid", 32'(bif.rsp_valid), 32'(e_rv));
`ifdef ARB_TIMEOUT_EN
    check("rsp_error", 32'(bif.rsp_error), 32'(e_err));
`endif
    if (g_any) begin
      check("bus_addr", bif.bus_addr, e_addr);
      check("bus_byte_enable", 32'(bif.bus_byte_enable), 32'(e_be));
      check("bus_write_data", bif.bus_write_data, e_wd);
    end
    if (e_rv != '0) check("rsp_data", bif.rsp_data, e_data);
  endtask

  // advance one clock edge and apply the model's state change
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_last = L - 1; m_owner = 0; m_cnt = 0;
      exp_q.delete();
    end else if (!m_busy) begin
      if (g_any) begin
        m_last = g_sel;
        if (g_read) begin
          m_busy = 1; m_owner = g_sel; m_cnt = 0;
          exp_q.push_back(rom(g_addr));
        end
      end
    end else begin
      if (g_done) begin
        m_busy = 0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        m_cnt++;
      end
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_all();
    set_rsp(1'b0, '0);
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // random-phase requester and follower state
  bit act[L];
  bit rd_c[L], wr_c[L];
  logic [31:0] ad_c[L], wd_c[L];
  logic [3:0] be_c[L];
  bit f_pend;
  int f_delay;
  logic [31:0] f_data;

  initial begin
    int r;
    clear_all();
    set_rsp(1'b0, '0);
    do_reset();

    // reset state: nothing granted, not busy
    sample();
    check("reset_ready", 32'(bif.req_ready), 32'h0);
    check("reset_busy", 32'(bif.busy), 32'h0);
    tick();

    // single read from requester 0 with a 1-cycle rom
    set_cmd(0, 1, 0, 32'h2000_0000, 4'hF, '0);
    sample();
    check("t1_ready", 32'(bif.req_ready), 32'h1);
    check("t1_read_req", 32'(bif.bus_read_req), 32'h1);
    tick();
    set_cmd(0, 1, 0, 32'h2000_0004, 4'hF, '0);
    set_rsp(1'b1, 32'h0000_000A);
    sample();
    check("t1_busy", 32'(bif.busy), 32'h1);
    check("t1_rsp_valid", 32'(bif.rsp_valid), 32'h1);
    check("t1_rsp_data", bif.rsp_data, 32'h0000_000A);
    check("t1_no_grant_on_rsp", 32'(bif.req_ready), 32'h0);
    tick();
    set_rsp(1'b0, '0);
    sample();
    check("t1_regrant", 32'(bif.req_ready), 32'h1);
    tick();
    clear_all();
    set_rsp(1'b1, rom(32'h2000_0004));
    cyc();
    set_rsp(1'b0, '0);

    // back-to-back posted writes alternate between requesters
    do_reset();
    set_cmd(0, 0, 1, 32'h1000_0000, 4'h1, 32'd1);
    set_cmd(1, 0, 1, 32'h1000_0000, 4'h1, 32'd2);
    for (int k = 0; k < 4; k++) begin
      sample();
      check("t2_grant", 32'(bif.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      check("t2_wdata", bif.bus_write_data, (k % 2 == 0) ? 32'd1 : 32'd2);
      check("t2_write_req", 32'(bif.bus_write_req), 32'h1);
      tick();
    end

    // read on 1 and write on 0 together: write first, then read, 0 blocked
    do_reset();
    set_cmd(1, 1, 0, 32'h3000_0010, 4'hF, '0);
    set_cmd(0, 0, 1, 32'h1000_0020, 4'h3, 32'h55);
    sample();
    check("t3_first_grant", 32'(bif.req_ready), 32'h1);
    tick();
    sample();
    check("t3_second_grant", 32'(bif.req_ready), 32'h2);
    check("t3_read_req", 32'(bif.bus_read_req), 32'h1);
    tick();
    set_cmd(1, 0, 0, '0, '0, '0);
    sample();
    check("t3_blocked", 32'(bif.req_ready), 32'h0);
    check("t3_busy", 32'(bif.busy), 32'h1);
    tick();
    set_rsp(1'b1, rom(32'h3000_0010));
    sample();
    check("t3_rsp_route", 32'(bif.rsp_valid), 32'h2);
    check("t3_blocked_rsp", 32'(bif.req_ready), 32'h0);
    tick();
    set_rsp(1'b0, '0);
    sample();
    check("t3_after", 32'(bif.req_ready), 32'h1);
    tick();
    clear_all();

    // stray response in IDLE
    set_rsp(1'b1, 32'h1234_5678);
    sample();
    check("t4_stray_valid", 32'(bif.rsp_valid), 32'h0);
    check("t4_stray_busy", 32'(bif.busy), 32'h0);
    tick();
    set_rsp(1'b0, '0);
    set_cmd(0, 0, 1, 32'h1000_0040, 4'hF, 32'hCAFE);
    sample();
    check("t4_still_idle", 32'(bif.req_ready), 32'h1);
    tick();
    clear_all();

    // reset in the middle of a read, late response afterwards
    set_cmd(1, 1, 0, 32'h3000_0080, 4'hF, '0);
    sample();
    check("t5_grant", 32'(bif.req_ready), 32'h2);
    tick();
    clear_all();
    sample();
    check("t5_busy", 32'(bif.busy), 32'h1);
    tick();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    set_rsp(1'b1, rom(32'h3000_0080));
    set_cmd(0, 0, 1, 32'h1000_0100, 4'hF, 32'h11);
    set_cmd(1, 0, 1, 32'h1000_0104, 4'hF, 32'h22);
    sample();
    check("t5_late_valid", 32'(bif.rsp_valid), 32'h0);
    check("t5_busy_cleared", 32'(bif.busy), 32'h0);
    check("t5_prio0", 32'(bif.req_ready), 32'h1);
    tick();
    clear_all();
    set_rsp(1'b0, '0);

`ifdef ARB_TIMEOUT_EN
    // watchdog expiry with a silent follower
    do_reset();
    set_cmd(0, 1, 0, 32'h4000_0000, 4'hF, '0);
    cyc();
    clear_all();
    for (int w = 1; w <= 4; w++) begin
      sample();
      if (w < 4) begin
        check("t6_wait_valid", 32'(bif.rsp_valid), 32'h0);
      end else begin
        check("t6_to_valid", 32'(bif.rsp_valid), 32'h1);
        check("t6_to_error", 32'(bif.rsp_error), 32'h1);
        check("t6_to_data", bif.rsp_data, 32'hDEAD_BEEF);
      end
      tick();
    end
    sample();
    check("t6_idle_after", 32'(bif.busy), 32'h0);
    tick();
`endif

    // randomized traffic against the reference model
    do_reset();
    f_pend = 0;
    f_delay = 0;
    f_data = '0;
    for (int i = 0; i < L; i++) act[i] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < L; i++) begin
        if (!act[i] && $urandom_range(0, 1) == 1) begin
          act[i] = 1;
          r = $urandom_range(0, 7);
          rd_c[i] = (r < 3) || (r == 7);
          wr_c[i] = (r >= 3);
          ad_c[i] = $urandom;
          be_c[i] = 4'($urandom_range(0, 15));
          wd_c[i] = $urandom;
        end
        set_cmd(i, act[i] & rd_c[i], act[i] & wr_c[i], ad_c[i], be_c[i], wd_c[i]);
      end
      if (f_pend && f_delay == 0) begin
        set_rsp(1'b1, f_data);
        f_pend = 0;
      end else begin
        if (f_pend) f_delay--;
        set_rsp(!f_pend && ($urandom_range(0, 7) == 0), $urandom);
      end
      sample();
      if (g_any) act[g_sel] = 0;
      if (g_read) begin
        f_pend = 1;
        f_delay = $urandom_range(0, 2);
        f_data = rom(g_addr);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
